page_table_writer: RTL and testbench
====================================

PAGE_TABLE_WRITER -- requirements
Module: page_table_writer

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port sel, input, 1: supervisor page-table window decoded (physical pages 0x0200-0x027F).
REQ-004 SHALL have port as_n, input, 1: CPU address strobe, active-low.
REQ-005 SHALL have port rw, input, 1: 1 = CPU read, 0 = CPU write.
REQ-006 SHALL have ports uds_n and lds_n, input, 1 each: CPU upper and lower byte strobes, active-low.
REQ-007 SHALL have port cpu_addr, input, 16: entry index, {task[3:0], vpage[23:12]}.
REQ-008 SHALL have port cpu_wdata, input, 16: CPU write data.
REQ-009 SHALL have port cpu_rdata, output, 16: CPU read data, valid while dtack_n = 0.
REQ-010 SHALL have port dtack_n, output, 1: CPU acknowledge, active-low.
REQ-011 SHALL have port bus_req, output, 1: request for the table RAM, taken from the MMU lookup path.
REQ-012 SHALL have port bus_gnt, input, 1: table RAM granted to this block.
REQ-013 SHALL have ports ram_addr (16), ram_wdata (16), ram_we_n (1), ram_oe_n (1), ram_ub_n (1), ram_lb_n (1), all output: table RAM drive.
REQ-014 SHALL have port ram_rdata, input, 16: table RAM read data.
REQ-015 SHALL have ports clr_start (input, 1), clr_task (input, 4), clr_value (input, 16): bulk-fill command.
REQ-016 SHALL have ports clr_busy (output, 1) and clr_done (output, 1, one-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, REQ, WRITE, READ, ACK, FILL.
REQ-018 In IDLE, SHALL move to REQ when sel = 1 and as_n = 0 and (uds_n = 0 or lds_n = 0), latching address, data, rw and strobes.
REQ-019 In IDLE, SHALL move to FILL when clr_start = 1, latching clr_task and clr_value and clearing the fill counter to 0; a CPU access arriving in the same cycle SHALL lose to clr_start.
REQ-020 SHALL assert bus_req in REQ, WRITE, READ and FILL, and SHALL drive ram_we_n = ram_oe_n = 1 whenever bus_gnt = 0.
REQ-021 REQ SHALL wait for bus_gnt = 1, then go to WRITE (rw = 0) or READ (rw = 1).
REQ-022 WRITE SHALL last exactly one cycle: ram_we_n = 0, ram_addr = latched address, ram_wdata = latched data, ram_ub_n/ram_lb_n = latched uds_n/lds_n.
REQ-023 READ SHALL last exactly one cycle: ram_oe_n = 0, ram_ub_n = ram_lb_n = 0, cpu_rdata latched from ram_rdata at end of cycle.
REQ-024 ACK SHALL hold dtack_n = 0 until as_n is sampled 1, then return to IDLE; write latency from as_n sample to dtack_n = 0 is 3 cycles with bus_gnt already high.
REQ-025 If as_n is sampled 1 in REQ, SHALL abandon the access (no RAM cycle) and return to IDLE.
REQ-026 FILL SHALL write clr_value to entry {clr_task, counter}, one entry per cycle while bus_gnt = 1; counter increments only on granted cycles and pauses while bus_gnt = 0.
REQ-027 FILL SHALL end after entry counter = 0xFFF is written (4096 writes): pulse clr_done for one cycle, return to IDLE.
REQ-028 clr_busy SHALL be 1 exactly while in FILL; clr_start SHALL be ignored outside IDLE.
REQ-029 CPU accesses arriving during FILL SHALL not be acknowledged until FILL completes, then SHALL be serviced normally.

Reset
REQ-030 On reset_n = 0 at a clock edge, SHALL enter IDLE, aborting any access or fill, with dtack_n = 1, bus_req = 0, ram_we_n = ram_oe_n = ram_ub_n = ram_lb_n = 1, ram_addr = 0, ram_wdata = 0, cpu_rdata = 0, clr_busy = 0, clr_done = 0, counter = 0.

Configuration
REQ-031 With macro PAGE_TABLE_WRITER_READBACK_EN defined, CPU reads SHALL perform the READ cycle.
REQ-032 Without PAGE_TABLE_WRITER_READBACK_EN defined, CPU reads SHALL skip REQ and READ, go directly to ACK, never assert bus_req, and return cpu_rdata = 0x0000.

Verification
REQ-033 Word write: bus_gnt = 1, cpu_addr 0x1002, data 0xBEEF, both strobes -> one ram_we_n pulse, ram_addr 0x1002, ram_wdata 0xBEEF, dtack_n low 3 cycles after as_n.
REQ-034 Byte write: lds_n = 0, uds_n = 1 to 0x4002 -> ram_lb_n = 0, ram_ub_n = 1 during WRITE.
REQ-035 Grant stall: bus_gnt = 0 for 5 cycles during a write -> no RAM strobe and dtack_n = 1 until gnt; as_n released early -> no RAM cycle at all.
REQ-036 Fill: clr_task 2, clr_value 0x0000, bus_gnt toggling -> exactly 4096 writes covering 0x2000-0x2FFF, one clr_done pulse, then a pending CPU write is acknowledged.
REQ-037 Readback: with macro, RAM holding 0x1234 at 0x0001 -> cpu_rdata 0x1234; without macro -> 0x0000 and bus_req never asserted.
REQ-038 Reset mid-fill at counter 0x100 -> all outputs at reset values next cycle, no further writes.

Source files
------------

// File: rtl/page_table_writer.sv
// Page-table writer: services CPU accesses to the supervisor page-table window
// and bulk-fills one task's 4096 entries, arbitrating for the table RAM via
// bus_req/bus_gnt.
// Optional feature: define PAGE_TABLE_WRITER_READBACK_EN to let CPU reads fetch
// entries from the table RAM; otherwise reads are acknowledged immediately with
// 0x0000 and never request the bus.
module page_table_writer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        as_n,
  input  logic        rw,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        dtack_n,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we_n,
  output logic        ram_oe_n,
  output logic        ram_ub_n,
  output logic        ram_lb_n,
  input  logic [15:0] ram_rdata,
  input  logic        clr_start,
  input  logic [3:0]  clr_task,
  input  logic [15:0] clr_value,
  output logic        clr_busy,
  output logic        clr_done
);

  typedef enum logic [2:0] {StIdle, StReq, StWrite, StRead, StAck, StFill} state_e;

  state_e      state_q;
  logic        rw_q;
  logic        uds_q;
  logic        lds_q;
  logic [11:0] count_q;
  logic [15:0] ram_addr_q;
  logic [15:0] ram_wdata_q;
  logic        ram_we_q;
  logic        ram_oe_q;
  logic        ram_ub_q;
  logic        ram_lb_q;
  logic [15:0] cpu_rdata_q;
  logic        dtack_q;
  logic        bus_req_q;
  logic        clr_busy_q;
  logic        clr_done_q;
  logic        cpu_hit;

  assign cpu_hit = sel && !as_n && (!uds_n || !lds_n);

  // Controller FSM with all outputs registered; CPU address/data are latched
  // straight into the RAM drive registers since they are only strobed later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rw_q        <= 1'b1;
      uds_q       <= 1'b1;
      lds_q       <= 1'b1;
      count_q     <= 12'h000;
      ram_addr_q  <= 16'h0000;
      ram_wdata_q <= 16'h0000;
      ram_we_q    <= 1'b1;
      ram_oe_q    <= 1'b1;
      ram_ub_q    <= 1'b1;
      ram_lb_q    <= 1'b1;
      cpu_rdata_q <= 16'h0000;
      dtack_q     <= 1'b1;
      bus_req_q   <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Fill wins over a simultaneous CPU access; the CPU keeps as_n low
          // and is picked up again once the fill returns here.
          if (clr_start) begin
            state_q     <= StFill;
            count_q     <= 12'h000;
            ram_addr_q  <= {clr_task, 12'h000};
            ram_wdata_q <= clr_value;
            ram_we_q    <= 1'b0;
            ram_ub_q    <= 1'b0;
            ram_lb_q    <= 1'b0;
            bus_req_q   <= 1'b1;
            clr_busy_q  <= 1'b1;
          end else if (cpu_hit) begin
            ram_addr_q  <= cpu_addr;
            ram_wdata_q <= cpu_wdata;
            rw_q        <= rw;
            uds_q       <= uds_n;
            lds_q       <= lds_n;
`ifdef PAGE_TABLE_WRITER_READBACK_EN
            state_q     <= StReq;
            bus_req_q   <= 1'b1;
`else
            if (rw) begin
              state_q     <= StAck;
              dtack_q     <= 1'b0;
              cpu_rdata_q <= 16'h0000;
            end else begin
              state_q   <= StReq;
              bus_req_q <= 1'b1;
            end
`endif
          end
        end
        StReq: begin
          if (as_n) begin
            state_q   <= StIdle;
            bus_req_q <= 1'b0;
          end else if (bus_gnt) begin
            if (rw_q) begin
              state_q  <= StRead;
              ram_oe_q <= 1'b0;
              ram_ub_q <= 1'b0;
              ram_lb_q <= 1'b0;
            end else begin
              state_q  <= StWrite;
              ram_we_q <= 1'b0;
              ram_ub_q <= uds_q;
              ram_lb_q <= lds_q;
            end
          end
        end
        StWrite: begin
          // A grant lost mid-cycle keeps the strobe pending rather than dropping it.
          if (bus_gnt) begin
            state_q   <= StAck;
            ram_we_q  <= 1'b1;
            ram_ub_q  <= 1'b1;
            ram_lb_q  <= 1'b1;
            bus_req_q <= 1'b0;
            dtack_q   <= 1'b0;
          end
        end
        StRead: begin
          if (bus_gnt) begin
            state_q     <= StAck;
            cpu_rdata_q <= ram_rdata;
            ram_oe_q    <= 1'b1;
            ram_ub_q    <= 1'b1;
            ram_lb_q    <= 1'b1;
            bus_req_q   <= 1'b0;
            dtack_q     <= 1'b0;
          end
        end
        StAck: begin
          if (as_n) begin
            state_q <= StIdle;
            dtack_q <= 1'b1;
          end
        end
        StFill: begin
          // One entry per granted cycle; the counter simply holds while ungranted.
          if (bus_gnt) begin
            count_q          <= count_q + 12'd1;
            ram_addr_q[11:0] <= count_q + 12'd1;
            if (count_q == 12'hFFF) begin
              state_q    <= StIdle;
              ram_we_q   <= 1'b1;
              ram_ub_q   <= 1'b1;
              ram_lb_q   <= 1'b1;
              bus_req_q  <= 1'b0;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM strobes are forced inactive whenever the table RAM is not ours.
  assign ram_we_n  = ram_we_q | ~bus_gnt;
  assign ram_oe_n  = ram_oe_q | ~bus_gnt;
  assign ram_ub_n  = ram_ub_q;
  assign ram_lb_n  = ram_lb_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dtack_n   = dtack_q;
  assign bus_req   = bus_req_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_page_table_writer.sv
// Directed bench for page_table_writer. Inputs change and outputs are sampled
// on the falling clock edge; a posedge monitor logs every RAM write strobe.
module tb_page_table_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel, as_n, rw, uds_n, lds_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dtack_n, bus_req, bus_gnt;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we_n, ram_oe_n, ram_ub_n, ram_lb_n;
  logic        clr_start;
  logic [3:0]  clr_task;
  logic [15:0] clr_value;
  logic        clr_busy, clr_done;

  int tests = 0;
  int fails = 0;

  // Write monitor state
  int          fill_cnt = 0;
  int          fill_err = 0;
  logic [15:0] fill_base = 16'h0000;
  int          cpu_cnt = 0;
  logic [15:0] last_addr, last_data;

  int  snap;
  bit  flag;
  int  cyc;

  always #5 clk = ~clk;

  // Table RAM model: one known entry, everything else a marker value
  assign ram_rdata = (ram_addr == 16'h0001) ? 16'h1234 : 16'hDEAD;

  page_table_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .as_n      (as_n),
    .rw        (rw),
    .uds_n     (uds_n),
    .lds_n     (lds_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .dtack_n   (dtack_n),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we_n  (ram_we_n),
    .ram_oe_n  (ram_oe_n),
    .ram_ub_n  (ram_ub_n),
    .ram_lb_n  (ram_lb_n),
    .ram_rdata (ram_rdata),
    .clr_start (clr_start),
    .clr_task  (clr_task),
    .clr_value (clr_value),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // A write happens on each rising edge that sees ram_we_n low
  always @(posedge clk) begin
    if (!ram_we_n) begin
      if (clr_busy) begin
        if (ram_addr !== fill_base + 16'(fill_cnt)) fill_err++;
        fill_cnt++;
      end else begin
        cpu_cnt++;
        last_addr = ram_addr;
        last_data = ram_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cpu_start(input logic r, input logic [15:0] a, input logic [15:0] d,
                           input logic u, input logic l);
    sel = 1'b1; as_n = 1'b0; rw = r; cpu_addr = a; cpu_wdata = d; uds_n = u; lds_n = l;
  endtask

  task automatic cpu_end();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; sel = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sel = 1'b0; as_n = 1'b1; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; bus_gnt = 1'b0;
    clr_start = 1'b0; clr_task = '0; clr_value = '0;
    step(); step();

    // Reset state
    chk("rst_dtack", dtack_n, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_we", ram_we_n, 1);
    chk("rst_oe", ram_oe_n, 1);
    chk("rst_ub_lb", {ram_ub_n, ram_lb_n}, 2'b11);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_wdata", ram_wdata, 16'h0000);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_clr", {clr_busy, clr_done}, 2'b00);
    reset_n = 1'b1;
    step();

    // Word write, grant already high: REQ, WRITE, then dtack on the third edge
    bus_gnt = 1'b1;
    snap = cpu_cnt;
    cpu_start(1'b0, 16'h1002, 16'hBEEF, 1'b0, 1'b0);
    step();
    chk("ww_req", {bus_req, dtack_n, ram_we_n}, 3'b111);
    step();
    chk("ww_we", ram_we_n, 0);
    chk("ww_addr", ram_addr, 16'h1002);
    chk("ww_wdata", ram_wdata, 16'hBEEF);
    chk("ww_strb", {ram_ub_n, ram_lb_n, dtack_n}, 3'b001);
    step();
    chk("ww_dtack", {dtack_n, ram_we_n}, 2'b01);
    cpu_end();
    step();
    chk("ww_release", dtack_n, 1);
    chk("ww_count", cpu_cnt - snap, 1);

    // Byte write on the lower lane only
    cpu_start(1'b0, 16'h4002, 16'h00A5, 1'b1, 1'b0);
    step(); step();
    chk("bw_we", ram_we_n, 0);
    chk("bw_lanes", {ram_ub_n, ram_lb_n}, 2'b10);
    chk("bw_addr", ram_addr, 16'h4002);
    step();
    chk("bw_dtack", dtack_n, 0);
    cpu_end();
    step();

    // Window not selected: no bus request, no acknowledge
    sel = 1'b0; as_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    step(); step(); step();
    chk("nosel", {bus_req, dtack_n}, 2'b01);
    cpu_end();
    step();

    // Grant stall: 5 ungranted cycles with no strobe and no acknowledge
    bus_gnt = 1'b0;
    snap = cpu_cnt;
    cpu_start(1'b0, 16'h0123, 16'h7777, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {bus_req, ram_we_n, dtack_n}, 3'b111);
      step();
    end
    bus_gnt = 1'b1;
    step();
    chk("stall_we", ram_we_n, 0);
    step();
    chk("stall_dtack", dtack_n, 0);
    chk("stall_written", {last_addr, last_data}, {16'h0123, 16'h7777});
    cpu_end();
    step();

    // Strobe released while still waiting for grant: access abandoned
    bus_gnt = 1'b0;
    snap = cpu_cnt;
    cpu_start(1'b0, 16'h0456, 16'h1111, 1'b0, 1'b0);
    step(); step();
    cpu_end();
    step();
    chk("abort_idle", bus_req, 0);
    bus_gnt = 1'b1;
    step(); step(); step();
    chk("abort_nowr", cpu_cnt - snap, 0);
    chk("abort_dtack", dtack_n, 1);

    // Fill task 2 with toggling grant; a CPU write arrives in the same cycle
    fill_cnt = 0; fill_err = 0; fill_base = 16'h2000;
    snap = cpu_cnt;
    clr_task = 4'd2; clr_value = 16'h0000; clr_start = 1'b1;
    cpu_start(1'b0, 16'h3005, 16'h5555, 1'b0, 1'b0);
    step();
    clr_start = 1'b0;
    chk("fill_busy", {clr_busy, bus_req}, 2'b11);
    flag = 1'b0;
    cyc = 0;
    while (!clr_done && cyc < 20000) begin
      if (!dtack_n) flag = 1'b1;
      bus_gnt = ~bus_gnt;
      cyc++;
      step();
    end
    chk("fill_done_seen", clr_done, 1);
    chk("fill_count", fill_cnt, 4096);
    chk("fill_addr_err", fill_err, 0);
    chk("fill_no_dtack", flag, 0);
    chk("fill_busy_off", clr_busy, 0);
    chk("fill_no_cpu_wr", cpu_cnt - snap, 0);
    step();
    chk("fill_done_pulse", clr_done, 0);
    cyc = 0;
    while (dtack_n && cyc < 50) begin
      bus_gnt = ~bus_gnt;
      cyc++;
      step();
    end
    chk("pend_dtack", dtack_n, 0);
    chk("pend_count", cpu_cnt - snap, 1);
    chk("pend_written", {last_addr, last_data}, {16'h3005, 16'h5555});
    cpu_end();
    bus_gnt = 1'b1;
    step();

    // CPU read of entry 0x0001
    flag = 1'b0;
    cyc = 0;
    cpu_start(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
    step();
    while (dtack_n && cyc < 20) begin
      if (bus_req) flag = 1'b1;
      cyc++;
      step();
    end
    chk("rd_dtack", dtack_n, 0);
`ifdef PAGE_TABLE_WRITER_READBACK_EN
    chk("rd_data", cpu_rdata, 16'h1234);
    chk("rd_bus_req", flag, 1);
`else
    chk("rd_data", cpu_rdata, 16'h0000);
    chk("rd_bus_req", flag, 0);
`endif
    cpu_end();
    step();

    // Reset in the middle of a fill once 0x100 entries are written
    fill_cnt = 0; fill_err = 0; fill_base = 16'h5000;
    clr_task = 4'd5; clr_value = 16'hA5A5; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    cyc = 0;
    while (fill_cnt < 256 && cyc < 400) begin
      cyc++;
      step();
    end
    chk("mid_count", fill_cnt, 256);
    reset_n = 1'b0;
    step();
    snap = fill_cnt;
    chk("mid_rst_dtack_req", {dtack_n, bus_req}, 2'b10);
    chk("mid_rst_strobes", {ram_we_n, ram_oe_n, ram_ub_n, ram_lb_n}, 4'hF);
    chk("mid_rst_addr", ram_addr, 16'h0000);
    chk("mid_rst_wdata", ram_wdata, 16'h0000);
    chk("mid_rst_rdata", cpu_rdata, 16'h0000);
    chk("mid_rst_clr", {clr_busy, clr_done}, 2'b00);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("mid_no_more_wr", fill_cnt - snap, 0);
    chk("mid_fill_err", fill_err, 0);
    chk("mid_idle", {clr_busy, bus_req}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
